// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Program-counter generator with fetch handshake, trap/mret,
//                misaligned-redirect detection and halt/resume.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic            halt_i,
    input  logic            resume_i,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic [1:0]      state_o
);

    localparam logic [XLEN-1:0] c_inc = XLEN'(INC);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] w_epc_nxt;
    logic            r_misalign;
    logic            w_misalign_nxt;
    logic            w_target_misaligned;
    logic [XLEN-1:0] w_pc_plus;

    assign w_target_misaligned = |redirect_target_i[ALIGN_BITS-1:0];
    assign w_pc_plus           = r_pc + c_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_epc      <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_misalign_nxt = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (trap_i) begin
                    w_epc_nxt = r_pc;
                    w_pc_nxt  = TRAP_VEC;
                end else if (mret_i) begin
                    w_pc_nxt = r_epc;
                end else if (redirect_i && w_target_misaligned) begin
                    w_epc_nxt      = r_pc;
                    w_pc_nxt       = TRAP_VEC;
                    w_misalign_nxt = 1'b1;
                end else if (redirect_i) begin
                    w_pc_nxt = redirect_target_i;
                end else if (halt_i) begin
                    w_state_nxt = ST_HALT;
                end else if (fetch_ready_i && !stall_i) begin
                    w_pc_nxt = w_pc_plus;
                end
            end
            ST_HALT: begin
                // mret, halt and stall have no effect while halted
                if (trap_i) begin
                    w_epc_nxt   = r_pc;
                    w_pc_nxt    = TRAP_VEC;
                    w_state_nxt = ST_RUN;
                end else if (redirect_i && w_target_misaligned) begin
                    w_epc_nxt      = r_pc;
                    w_pc_nxt       = TRAP_VEC;
                    w_misalign_nxt = 1'b1;
                    w_state_nxt    = ST_RUN;
                end else if (redirect_i) begin
                    w_pc_nxt    = redirect_target_i;
                    w_state_nxt = ST_RUN;
                end else if (resume_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    assign pc_o          = r_pc;
    assign pc_plus_o     = w_pc_plus;
    assign epc_o         = r_epc;
    assign misalign_o    = r_misalign;
    assign fetch_valid_o = (r_state == ST_RUN);
    assign state_o       = r_state;

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the single-cycle/fetch front end. Replaces the plain PC register plus the separate +4 adder with one block. It holds the PC, chooses the next PC from sequential / redirect / trap / return sources, and tracks a saved exception PC (EPC). It also runs a valid/ready fetch handshake toward instruction memory, detects misaligned redirect targets, and supports halt/resume.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero (2 = word, 1 = halfword); legal range 1..3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
stall_i  in  1  hold PC; sequential advance suppressed
redirect_i  in  1  branch/jump taken
redirect_target_i  in  XLEN  branch/jump target
trap_i  in  1  exception request from execute
mret_i  in  1  return from trap to epc_o
halt_i  in  1  enter HALT
resume_i  in  1  leave HALT, continue at pc_o
fetch_ready_i  in  1  imem accepts current pc_o
pc_o  out  XLEN  current PC / fetch address
pc_plus_o  out  XLEN  pc_o + INC, combinational, for link register
fetch_valid_o  out  1  pc_o is a valid fetch request
epc_o  out  XLEN  saved exception PC
misalign_o  out  1  one-cycle pulse: redirect target misaligned, trap taken
state_o  out  2  00 BOOT, 01 RUN, 10 HALT

Behaviour:
- Reset (rst_n=0, async): pc_o=RESET_VEC, epc_o=RESET_VEC, state=BOOT, fetch_valid_o=0, misalign_o=0.
- BOOT: lasts exactly one cycle after rst_n deasserts. Then RUN; pc_o unchanged.
- fetch_valid_o = (state==RUN). Combinational from state only.
- All events below are evaluated only in RUN, except where HALT is noted.
- Event priority, highest first: trap_i > mret_i > misaligned redirect > redirect_i > halt_i > sequential.
- trap_i: epc_o<=pc_o; pc_o<=TRAP_VEC. Ignores stall_i and fetch_ready_i.
- mret_i: pc_o<=epc_o. epc_o unchanged.
- redirect_i with redirect_target_i[ALIGN_BITS-1:0]!=0 (misaligned):
  - epc_o<=pc_o; pc_o<=TRAP_VEC; misalign_o=1 for the next cycle only.
- redirect_i with aligned target: pc_o<=redirect_target_i.
- Redirect, trap and mret override stall_i and do not need fetch_ready_i. The pending fetch is discarded.
- halt_i: state<=HALT; pc_o held.
- Sequential: pc_o<=pc_o+INC only when fetch_valid_o && fetch_ready_i && !stall_i. Otherwise pc_o holds.
- Arithmetic is modulo 2^XLEN: all-ones minus INC+1 wraps to 0, with no flag. pc_plus_o wraps the same way.
- HALT: fetch_valid_o=0; pc_o held.
  - trap_i: trap action, then RUN.
  - redirect_i: aligned or misaligned handling as in RUN, then RUN.
  - resume_i: RUN, pc_o unchanged.
  - halt_i and stall_i are ignored.
- mret_i in HALT or BOOT is ignored. trap_i/redirect_i in BOOT are ignored.
- Reset mid-operation: immediate return to reset values regardless of state or pending events.
- Exactly one PC update per cycle; no internal queue of events.

Test Plan:
- Reset release, fetch_ready_i=1, no events -> pc_o: 0 (BOOT, valid=0), 0 (RUN, valid=1), 4, 8, 12 on successive cycles.
- At pc_o=0x10, fetch_ready_i=0 for 3 cycles, then stall_i=1 for 2 cycles -> pc_o stays 0x10 throughout; advances to 0x14 once ready=1 and stall=0.
- At pc_o=0x20, redirect_i=1, target=0x80 with stall_i=1 -> next pc_o=0x80; same test with target=0x82 -> pc_o=0x100, epc_o=0x20, misalign_o high for one cycle.
- At pc_o=0x40, trap_i=1 and redirect_i=1 (target 0x80) in the same cycle -> pc_o=0x100, epc_o=0x40. Then mret_i=1 -> pc_o=0x40.
- halt_i at pc_o=0x50 -> state=HALT, valid=0, pc_o=0x50 for 5 cycles. resume_i -> RUN, fetch 0x50 then 0x54. Repeat with redirect to 0x200 instead of resume -> pc_o=0x200 in RUN.
- pc_o forced via redirect to 0xFFFF_FFFC, ready=1 -> next pc_o=0x0, pc_plus_o=0x4. Assert rst_n=0 mid-stream -> pc_o=0 same cycle (async), state=BOOT.
